// File: rtl/tics_flop_bank_ctrl.sv
// tics_flop_bank_ctrl
// Sequencer and round-robin arbiter for a DEPTH x WIDTH bank of tics flop cells.
// Two requesters (A, B) share the bank. Writes are expanded into select/data
// setup, a one-cycle latch strobe and a hold phase. Reads sample the selected
// word of the cell Q bus and return it as a one-cycle rd_valid pulse.
//
// Optional feature macro: TICS_CLEAR_EN
//   Defined   : every write first spends one CLEAR cycle with out_clr = 1.
//   Undefined : the CLEAR state does not exist and out_clr is always 0.
module tics_flop_bank_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 2,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                     in_clk,
    input  logic                     in_rst,

    input  logic                     req_a_valid,
    output logic                     req_a_ready,
    input  logic                     req_a_we,
    input  logic [ADDR_W-1:0]        req_a_addr,
    input  logic [WIDTH-1:0]         req_a_data,

    input  logic                     req_b_valid,
    output logic                     req_b_ready,
    input  logic                     req_b_we,
    input  logic [ADDR_W-1:0]        req_b_addr,
    input  logic [WIDTH-1:0]         req_b_data,

    output logic                     rd_valid,
    output logic                     rd_id,
    output logic [WIDTH-1:0]         rd_data,

    output logic [DEPTH-1:0]         out_sel,
    output logic [WIDTH-1:0]         out_d,
    output logic                     out_strobe,
    output logic                     out_clr,
    input  logic [DEPTH*WIDTH-1:0]   in_q,

    output logic                     busy
);

    // Phase counter is wide enough for the longer of the setup and hold phases.
    localparam int MAX_CYC = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_CYC);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
`ifdef TICS_CLEAR_EN
        ST_CLEAR  = 3'd1,
`endif
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_READ   = 3'd5,
        ST_RDOUT  = 3'd6
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;

    // rr_last_b_q = 1 means B was served last, so A wins the next tie.
    logic               rr_last_b_q;
    logic               owner_b_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   rd_data_q;

    logic               grant_a;
    logic               grant_b;
    logic               xfer;
    logic               xfer_we;
    logic [DEPTH-1:0]   sel_hot;
    logic [WIDTH-1:0]   rd_word;

    // Round-robin grant, only offered while idle and out of reset.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == ST_IDLE && !in_rst) begin
            if (req_a_valid && (!req_b_valid || rr_last_b_q)) begin
                grant_a = 1'b1;
            end else if (req_b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign req_a_ready = grant_a;
    assign req_b_ready = grant_b;
    assign xfer        = grant_a | grant_b;
    assign xfer_we     = grant_b ? req_b_we : req_a_we;

    // Decode the latched address; out-of-range addresses select no word and read 0.
    always_comb begin
        sel_hot = '0;
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                sel_hot[i] = 1'b1;
                rd_word    = in_q[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register and phase counter; the counter restarts on every state change and saturates.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Capture the granted request and advance the round-robin pointer on each transfer.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            rr_last_b_q <= 1'b1;
            owner_b_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else if (xfer) begin
            rr_last_b_q <= grant_b;
            owner_b_q   <= grant_b;
            we_q        <= xfer_we;
            addr_q      <= grant_b ? req_b_addr : req_a_addr;
            data_q      <= grant_b ? req_b_data : req_a_data;
        end
    end

    // Read data is sampled at the end of READ and held until the next read.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            rd_data_q <= '0;
        end else if (state_q == ST_READ) begin
            rd_data_q <= rd_word;
        end
    end

    assign rd_data = rd_data_q;

    // Next-state logic for the write and read sequences.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (xfer_we) begin
`ifdef TICS_CLEAR_EN
                        state_d = ST_CLEAR;
`else
                        state_d = ST_SETUP;
`endif
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
`ifdef TICS_CLEAR_EN
            ST_CLEAR: begin
                state_d = ST_SETUP;
            end
`endif
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                state_d = ST_RDOUT;
            end
            ST_RDOUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Cell-side and read-return outputs decoded from the current state.
    always_comb begin
        out_sel    = '0;
        out_d      = '0;
        out_strobe = 1'b0;
        out_clr    = 1'b0;
        rd_valid   = 1'b0;
        rd_id      = 1'b0;
        case (state_q)
`ifdef TICS_CLEAR_EN
            ST_CLEAR: begin
                out_clr = 1'b1;
                out_sel = sel_hot;
            end
`endif
            ST_SETUP: begin
                out_sel = sel_hot;
                out_d   = data_q;
            end
            ST_STROBE: begin
                out_sel    = sel_hot;
                out_d      = data_q;
                out_strobe = 1'b1;
            end
            ST_HOLD: begin
                out_sel = sel_hot;
                out_d   = data_q;
            end
            ST_READ: begin
                out_sel = sel_hot;
            end
            ST_RDOUT: begin
                rd_valid = 1'b1;
                rd_id    = owner_b_q;
            end
            default: begin
                out_sel = '0;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    // The latched write-enable only steers the IDLE decision through xfer_we;
    // keep it referenced so the captured request stays complete for debug.
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_tics_flop_bank_ctrl.sv
// tb_tics_flop_bank_ctrl
// Self-checking bench for tics_flop_bank_ctrl (DEPTH=3 so address 3 is out of range).
// Expected cell writes and read returns go into scoreboard queues when a request
// is driven and are popped when the DUT strobes or pulses rd_valid.
// Build with +define+TICS_CLEAR_EN to exercise the clear phase.
module tb_tics_flop_bank_ctrl;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 3;
    localparam int ADDR_W    = 2;
    localparam int SETUP_CYC = 2;
    localparam int HOLD_CYC  = 1;
`ifdef TICS_CLEAR_EN
    localparam int CLR_CYC   = 1;
`else
    localparam int CLR_CYC   = 0;
`endif

    logic                    in_clk;
    logic                    in_rst;
    logic                    req_a_valid, req_a_ready, req_a_we;
    logic [ADDR_W-1:0]       req_a_addr;
    logic [WIDTH-1:0]        req_a_data;
    logic                    req_b_valid, req_b_ready, req_b_we;
    logic [ADDR_W-1:0]       req_b_addr;
    logic [WIDTH-1:0]        req_b_data;
    logic                    rd_valid, rd_id;
    logic [WIDTH-1:0]        rd_data;
    logic [DEPTH-1:0]        out_sel;
    logic [WIDTH-1:0]        out_d;
    logic                    out_strobe, out_clr;
    logic [DEPTH*WIDTH-1:0]  in_q;
    logic                    busy;

    logic [WIDTH-1:0]        cells [DEPTH];

    int checks = 0;
    int errors = 0;
    int clr_seen = 0;

    typedef struct packed {
        logic [DEPTH-1:0] sel;
        logic [WIDTH-1:0] d;
    } wr_exp_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             id;
    } rd_exp_t;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];

    tics_flop_bank_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .req_a_valid(req_a_valid), .req_a_ready(req_a_ready), .req_a_we(req_a_we),
        .req_a_addr(req_a_addr), .req_a_data(req_a_data),
        .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_we(req_b_we),
        .req_b_addr(req_b_addr), .req_b_data(req_b_data),
        .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
        .out_sel(out_sel), .out_d(out_d), .out_strobe(out_strobe), .out_clr(out_clr),
        .in_q(in_q), .busy(busy)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Cell Q bus is driven from the bench-owned word array.
    always_comb begin
        in_q = '0;
        for (int i = 0; i < DEPTH; i++) in_q[i*WIDTH +: WIDTH] = cells[i];
    end

    always @(negedge in_clk) if (out_clr) clr_seen++;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DEPTH-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [DEPTH-1:0] r;
        r = '0;
        if (int'(a) < DEPTH) r[a] = 1'b1;
        return r;
    endfunction

    task automatic idle_inputs();
        req_a_valid = 0; req_a_we = 0; req_a_addr = '0; req_a_data = '0;
        req_b_valid = 0; req_b_we = 0; req_b_addr = '0; req_b_data = '0;
    endtask

    task automatic pulse_reset();
        @(negedge in_clk); in_rst = 1'b1;
        @(negedge in_clk); in_rst = 1'b0;
    endtask

    task automatic test_reset();
        wr_exp_t unused;
        idle_inputs();
        in_rst = 1'b1;
        repeat (2) @(posedge in_clk);
        @(negedge in_clk);
        checks++;
        if ({busy, out_strobe, out_clr, rd_valid, rd_id, out_sel, out_d, rd_data,
             req_a_ready, req_b_ready} !== '0)
            begin errors++; $display("[TB] FAIL reset_outputs: got busy=%b sel=%b d=%h rd=%h expected all zero",
                                     busy, out_sel, out_d, rd_data); end
        in_rst = 1'b0;
        unused = '0;
    endtask

    task automatic test_write_seq();
        wr_exp_t e, got;
        int total;
        @(negedge in_clk);
        req_a_valid = 1; req_a_we = 1; req_a_addr = 2'd1; req_a_data = 8'hA5;
        #1;
        checks++;
        if (req_a_ready !== 1'b1) begin errors++; $display("[TB] FAIL write_ready_a: got %b expected 1", req_a_ready); end
        e.sel = onehot(2'd1); e.d = 8'hA5; wr_q.push_back(e);
        @(posedge in_clk); #1; req_a_valid = 0;
        total = CLR_CYC + SETUP_CYC + 1 + HOLD_CYC + 1;
        for (int n = 0; n < total; n++) begin
            logic ebusy, eclr, estr;
            logic [DEPTH-1:0] esel;
            logic [WIDTH-1:0] ed;
            @(negedge in_clk);
            ebusy = 1; eclr = 0; estr = 0; esel = 3'b010; ed = 8'hA5;
            if (n < CLR_CYC) begin eclr = 1; ed = '0; end
            else if (n < CLR_CYC + SETUP_CYC) begin end
            else if (n == CLR_CYC + SETUP_CYC) estr = 1;
            else if (n < CLR_CYC + SETUP_CYC + 1 + HOLD_CYC) begin end
            else begin ebusy = 0; esel = '0; ed = '0; end
            checks++;
            if ({busy, out_clr, out_strobe, out_sel, out_d} !== {ebusy, eclr, estr, esel, ed})
                begin errors++; $display("[TB] FAIL write_phase n=%0d: got busy=%b clr=%b stb=%b sel=%b d=%h expected busy=%b clr=%b stb=%b sel=%b d=%h",
                    n, busy, out_clr, out_strobe, out_sel, out_d, ebusy, eclr, estr, esel, ed); end
            if (out_strobe && wr_q.size() > 0) begin
                e = wr_q.pop_front(); got.sel = out_sel; got.d = out_d;
                checks++;
                if (got !== e) begin errors++; $display("[TB] FAIL write_sb: got %h expected %h", got, e); end
            end
        end
        checks++;
        if (wr_q.size() != 0) begin errors++; $display("[TB] FAIL write_strobe_seen: got %0d pending expected 0", wr_q.size()); wr_q.delete(); end
    endtask

    task automatic test_arbitration();
        logic [3:0] obs;
        wr_exp_t e, got;
        int ng, ns, cyc;
        pulse_reset();
        obs = '0; ng = 0; ns = 0; cyc = 0;
        @(negedge in_clk);
        req_a_valid = 1; req_a_we = 1; req_a_addr = 2'd0; req_a_data = 8'h11;
        req_b_valid = 1; req_b_we = 1; req_b_addr = 2'd2; req_b_data = 8'h22;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin e.sel = 3'b001; e.d = 8'h11; end
            else            begin e.sel = 3'b100; e.d = 8'h22; end
            wr_q.push_back(e);
        end
        #1;
        while ((ng < 4 || ns < 4) && cyc < 200) begin
            if (cyc > 0) @(negedge in_clk);
            #1;
            cyc++;
            if (out_strobe) begin
                got.sel = out_sel; got.d = out_d;
                checks++;
                if (wr_q.size() == 0) begin errors++; $display("[TB] FAIL arb_sb: got extra strobe expected none"); end
                else begin
                    e = wr_q.pop_front();
                    if (got !== e) begin errors++; $display("[TB] FAIL arb_sb: got %h expected %h", got, e); end
                end
                ns++;
            end
            if (req_a_valid || req_b_valid) begin
                checks++;
                if ((req_a_ready && req_b_ready) || (busy && (req_a_ready || req_b_ready)))
                    begin errors++; $display("[TB] FAIL arb_ready: got a=%b b=%b busy=%b expected one ready only in idle",
                                             req_a_ready, req_b_ready, busy); end
                if (req_a_ready) begin obs[ng] = 1'b0; ng++; end
                else if (req_b_ready) begin obs[ng] = 1'b1; ng++; end
                if (ng == 4) begin
                    @(posedge in_clk); #1;
                    req_a_valid = 0; req_b_valid = 0;
                end
            end
        end
        checks++;
        if (cyc >= 200) begin errors++; $display("[TB] FAIL arb_timeout: got %0d grants %0d strobes expected 4 and 4", ng, ns); end
        checks++;
        if (obs !== 4'b1010) begin errors++; $display("[TB] FAIL arb_order: got %b expected 1010 (bit0 first, 1=B)", obs); end
        wr_q.delete();
        cyc = 0;
        while (busy && cyc < 20) begin @(negedge in_clk); cyc++; end
    endtask

    task automatic test_read();
        rd_exp_t e, got;
        int cyc;
        cells[0] = 8'h5A; cells[1] = 8'hC3; cells[2] = 8'h3C;
        @(negedge in_clk);
        req_b_valid = 1; req_b_we = 0; req_b_addr = 2'd2;
        #1;
        checks++;
        if (req_b_ready !== 1'b1) begin errors++; $display("[TB] FAIL read_ready_b: got %b expected 1", req_b_ready); end
        e.data = 8'h3C; e.id = 1'b1; rd_q.push_back(e);
        @(posedge in_clk); #1;
        req_b_valid = 0;
        req_a_valid = 1; req_a_we = 0; req_a_addr = 2'd0;
        e.data = 8'h5A; e.id = 1'b0; rd_q.push_back(e);
        @(negedge in_clk);
        checks++;
        if ({busy, out_sel, req_a_ready, rd_valid} !== {1'b1, 3'b100, 1'b0, 1'b0})
            begin errors++; $display("[TB] FAIL read_cycle0: got busy=%b sel=%b rdya=%b rv=%b expected 1 100 0 0",
                                     busy, out_sel, req_a_ready, rd_valid); end
        @(negedge in_clk);
        checks++;
        if (rd_valid !== 1'b1 || req_a_ready !== 1'b0)
            begin errors++; $display("[TB] FAIL read_pulse_b: got rv=%b rdya=%b expected 1 0", rd_valid, req_a_ready); end
        else begin
            e = rd_q.pop_front(); got.data = rd_data; got.id = rd_id;
            checks++;
            if (got !== e) begin errors++; $display("[TB] FAIL read_sb_b: got %h expected %h", got, e); end
        end
        @(negedge in_clk);
        checks++;
        if ({rd_valid, req_a_ready, busy} !== 3'b010)
            begin errors++; $display("[TB] FAIL read_after: got rv=%b rdya=%b busy=%b expected 0 1 0", rd_valid, req_a_ready, busy); end
        @(posedge in_clk); #1;
        req_a_valid = 0;
        cyc = 0;
        @(negedge in_clk);
        while (!rd_valid && cyc < 10) begin @(negedge in_clk); cyc++; end
        checks++;
        if (!rd_valid || rd_q.size() == 0) begin errors++; $display("[TB] FAIL read_a_timeout: got rv=%b expected 1", rd_valid); end
        else begin
            e = rd_q.pop_front(); got.data = rd_data; got.id = rd_id;
            if (got !== e) begin errors++; $display("[TB] FAIL read_sb_a: got %h expected %h", got, e); end
        end
        @(negedge in_clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h5A)
            begin errors++; $display("[TB] FAIL read_hold: got rv=%b rd=%h expected 0 5a", rd_valid, rd_data); end
        rd_q.delete();
    endtask

    task automatic test_out_of_range();
        wr_exp_t we_e, wgot;
        rd_exp_t re, rgot;
        int cyc, nstr, badsel;
        @(negedge in_clk);
        req_a_valid = 1; req_a_we = 1; req_a_addr = 2'd3; req_a_data = 8'hFF;
        #1;
        checks++;
        if (req_a_ready !== 1'b1) begin errors++; $display("[TB] FAIL oor_ready: got %b expected 1", req_a_ready); end
        we_e.sel = '0; we_e.d = 8'hFF; wr_q.push_back(we_e);
        @(posedge in_clk); #1; req_a_valid = 0;
        nstr = 0; badsel = 0; cyc = 0;
        @(negedge in_clk);
        while (busy && cyc < 12) begin
            if (out_sel !== '0) badsel++;
            if (out_strobe) begin
                nstr++;
                if (wr_q.size() > 0) begin
                    we_e = wr_q.pop_front(); wgot.sel = out_sel; wgot.d = out_d;
                    checks++;
                    if (wgot !== we_e) begin errors++; $display("[TB] FAIL oor_sb: got %h expected %h", wgot, we_e); end
                end
            end
            @(negedge in_clk); cyc++;
        end
        checks++;
        if (badsel != 0) begin errors++; $display("[TB] FAIL oor_sel: got %0d nonzero cycles expected 0", badsel); end
        checks++;
        if (nstr != 1) begin errors++; $display("[TB] FAIL oor_strobe: got %0d strobes expected 1", nstr); end
        req_a_valid = 1; req_a_we = 0; req_a_addr = 2'd3;
        re.data = '0; re.id = 1'b0; rd_q.push_back(re);
        @(posedge in_clk); #1; req_a_valid = 0;
        cyc = 0;
        @(negedge in_clk);
        while (!rd_valid && cyc < 10) begin @(negedge in_clk); cyc++; end
        checks++;
        if (!rd_valid) begin errors++; $display("[TB] FAIL oor_read_timeout: got rv=0 expected 1"); end
        else begin
            re = rd_q.pop_front(); rgot.data = rd_data; rgot.id = rd_id;
            if (rgot !== re) begin errors++; $display("[TB] FAIL oor_read: got %h expected %h", rgot, re); end
        end
        rd_q.delete(); wr_q.delete();
        @(negedge in_clk);
    endtask

    task automatic test_reset_mid();
        int nstr;
        @(negedge in_clk);
        req_a_valid = 1; req_a_we = 1; req_a_addr = 2'd1; req_a_data = 8'h77;
        @(posedge in_clk); #1; req_a_valid = 0;
        for (int n = 0; n <= CLR_CYC; n++) @(negedge in_clk);
        checks++;
        if (busy !== 1'b1 || out_d !== 8'h77)
            begin errors++; $display("[TB] FAIL midrst_setup: got busy=%b d=%h expected 1 77", busy, out_d); end
        in_rst = 1'b1;
        @(negedge in_clk);
        checks++;
        if ({busy, out_strobe, out_clr, rd_valid, rd_id, out_sel, out_d, rd_data} !== '0)
            begin errors++; $display("[TB] FAIL midrst_outputs: got busy=%b stb=%b sel=%b d=%h expected all zero",
                                     busy, out_strobe, out_sel, out_d); end
        in_rst = 1'b0;
        nstr = 0;
        for (int n = 0; n < 6; n++) begin @(negedge in_clk); if (out_strobe) nstr++; end
        checks++;
        if (nstr != 0) begin errors++; $display("[TB] FAIL midrst_no_strobe: got %0d strobes expected 0", nstr); end
        req_a_valid = 1; req_a_we = 1; req_a_addr = 2'd0; req_a_data = 8'h01;
        req_b_valid = 1; req_b_we = 1; req_b_addr = 2'd1; req_b_data = 8'h02;
        #1;
        checks++;
        if ({req_a_ready, req_b_ready} !== 2'b10)
            begin errors++; $display("[TB] FAIL midrst_tie: got a=%b b=%b expected 1 0", req_a_ready, req_b_ready); end
        idle_inputs();
        @(negedge in_clk);
    endtask

    task automatic test_clear_flag();
        checks++;
`ifdef TICS_CLEAR_EN
        if (clr_seen != 7) begin errors++; $display("[TB] FAIL clear_count: got %0d expected 7", clr_seen); end
`else
        if (clr_seen != 0) begin errors++; $display("[TB] FAIL clear_absent: got %0d expected 0", clr_seen); end
`endif
    endtask

    initial begin
        in_rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) cells[i] = '0;
        test_reset();
        test_write_seq();
        test_arbitration();
        test_read();
        test_out_of_range();
        test_reset_mid();
        test_clear_flag();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
